// File: rtl/int_ctrl.sv
// ---------------------------------------------------------------------------
// int_ctrl -- interrupt controller between peripheral IRQ lines and CP0 HWInt
//
// Latches a pending bit per source in level or edge mode, gates it with a
// software mask and drives hwint[5:0] towards CP0. A 4-word register file
// on the bus bridge provides configuration, write-one-to-clear and a
// highest-priority claim register.
//
// Register map (addr[3:2]):
//   0x0 PEND  RO, W1C for edge-mode sources
//   0x4 MASK  RW
//   0x8 MODE  RW (0 = level, 1 = edge)
//   0xC ID    RO, {valid, 28'b0, idx[2:0]}; a read with re=1 claims idx
//
// Ports:
//   clk    in   1   clock
//   reset  in   1   synchronous active-high reset
//   irq    in   6   raw source lines, bit0 = highest priority
//   addr   in   4   byte offset, addr[1:0] ignored
//   we     in   1   write strobe
//   wdata  in   32  write data
//   re     in   1   read strobe (only used for the ID claim side effect)
//   rdata  out  32  read data, combinational from addr
//   hwint  out  6   pend & mask to CP0
// ---------------------------------------------------------------------------
module int_ctrl #(
  parameter int         NSRC     = 6,
  parameter logic [5:0] MASK_RST = 6'h3f,
  parameter logic [5:0] MODE_RST = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  irq,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        re,
  output logic [31:0] rdata,
  output logic [5:0]  hwint
);

  // Bits of the 6-wide vectors that correspond to implemented sources.
  localparam logic [5:0] VALID_BITS = 6'((7'd1 << NSRC) - 7'd1);

  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_MODE = 2'd2;
  localparam logic [1:0] REG_ID   = 2'd3;

  logic [5:0] r_pend;
  logic [5:0] r_mask;
  logic [5:0] r_mode;
  logic [5:0] r_irq_q;

  logic [5:0] w_rise;
  logic [5:0] w_act;
  logic [5:0] w_w1c;
  logic [5:0] w_claim_sel;
  logic [5:0] w_clr;
  logic [2:0] w_idx;
  logic       w_valid;
  logic       w_claim;
  logic       w_unused;

  assign w_rise  = irq & ~r_irq_q;
  assign w_act   = r_pend & r_mask & VALID_BITS;
  assign w_valid = |w_act;

  // Lowest set index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_act[i]) w_idx = 3'(i);
    end
  end

  assign w_claim     = re && (addr[3:2] == REG_ID) && w_valid;
  assign w_claim_sel = w_claim ? (6'd1 << w_idx) : 6'd0;
  assign w_w1c       = (we && (addr[3:2] == REG_PEND)) ? wdata[5:0] : 6'd0;
  assign w_clr       = w_w1c | w_claim_sel;

  // Per-source pending latch. Level sources simply follow irq; edge
  // sources set on a rising edge and hold until cleared, with the set
  // taking precedence over a clear in the same cycle.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pend
      always_ff @(posedge clk) begin
        if (reset || !VALID_BITS[gi]) begin
          r_pend[gi] <= 1'b0;
        end else if (!r_mode[gi]) begin
          r_pend[gi] <= irq[gi];
        end else if (w_rise[gi]) begin
          r_pend[gi] <= 1'b1;
        end else if (w_clr[gi]) begin
          r_pend[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // irq_q always tracks irq, so switching a source to edge mode never
  // sees a stale low history and cannot produce a spurious rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= MASK_RST;
      r_mode  <= MODE_RST;
      r_irq_q <= 6'd0;
    end else begin
      r_irq_q <= irq;
      if (we && (addr[3:2] == REG_MASK)) r_mask <= wdata[5:0];
      if (we && (addr[3:2] == REG_MODE)) r_mode <= wdata[5:0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr[3:2])
      REG_PEND: rdata = {26'd0, r_pend};
      REG_MASK: rdata = {26'd0, r_mask};
      REG_MODE: rdata = {26'd0, r_mode};
      REG_ID:   rdata = w_valid ? {1'b1, 28'd0, w_idx} : 32'd0;
      default:  rdata = 32'd0;
    endcase
  end

  assign hwint = w_act;

  // Upper write-data bits and the byte offset carry no information here.
  assign w_unused = &{1'b0, wdata[31:6], addr[1:0]};

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  irq = 6'd0;
  logic [3:0]  addr = 4'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic [5:0]  hwint;

  int total = 0;
  int bad = 0;

  int_ctrl #(.NSRC(6), .MASK_RST(6'h3f), .MODE_RST(6'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .irq   (irq),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .re    (re),
    .rdata (rdata),
    .hwint (hwint)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit       m_ok = 0;
  bit [5:0] m_pend, m_mask, m_mode, m_prev_irq;

  function automatic int first_active();
    for (int i = 0; i < 6; i++)
      if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [3:0] a);
    int f;
    case (a[3:2])
      2'd0: return {26'd0, m_pend};
      2'd1: return {26'd0, m_mask};
      2'd2: return {26'd0, m_mode};
      default: begin
        f = first_active();
        if (f < 0) return 32'd0;
        return 32'h8000_0000 + 32'(f);
      end
    endcase
  endfunction

  always @(posedge clk) begin
    int claimed;
    bit [5:0] np;
    if (reset) begin
      m_ok = 1;
      m_pend = 0; m_mask = 6'h3f; m_mode = 0; m_prev_irq = 0;
    end else if (m_ok) begin
      claimed = (re && addr[3:2] == 2'd3) ? first_active() : -1;
      for (int i = 0; i < 6; i++) begin
        if (!m_mode[i]) np[i] = irq[i];
        else if (irq[i] && !m_prev_irq[i]) np[i] = 1;
        else if ((we && addr[3:2] == 2'd0 && wdata[i]) || i == claimed) np[i] = 0;
        else np[i] = m_pend[i];
      end
      m_pend = np;
      if (we && addr[3:2] == 2'd1) m_mask = wdata[5:0];
      if (we && addr[3:2] == 2'd2) m_mode = wdata[5:0];
      m_prev_irq = irq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_hwint", {26'd0, hwint}, {26'd0, m_pend & m_mask});
      chk("model_rdata", rdata, exp_rdata(addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
    $display("txn write addr=0x%h data=0x%08h", a, d);
  endtask

  initial begin
    // 1: reset defaults, level passthrough
    reset = 1'b1; addr = 4'h4;
    cyc();
    chk("rst_hwint", {26'd0, hwint}, 32'd0);
    chk("rst_mask", rdata, 32'h3f);
    addr = 4'h8; #1;
    chk("rst_mode", rdata, 32'h0);
    reset = 1'b0; irq = 6'b000100; addr = 4'h0;
    cyc();
    chk("t1_hwint", {26'd0, hwint}, 32'h4);
    chk("t1_pend", rdata, 32'h4);
    $display("txn t1 reset/level");

    // 2: edge mode, pulse, W1C
    irq = 6'd0;
    wr(4'h8, 32'h3f);
    irq = 6'b000010; cyc();
    irq = 6'd0; cyc(); cyc();
    chk("t2_hold", {26'd0, hwint}, 32'h2);
    wr(4'h0, 32'h2);
    chk("t2_w1c", {26'd0, hwint}, 32'h0);
    $display("txn t2 edge/w1c");

    // 3: priority and claim
    irq = 6'b100101; cyc();
    irq = 6'd0; cyc();
    re = 1'b1; addr = 4'hC; #1;
    chk("t3_id0", rdata, 32'h8000_0000);
    cyc();
    re = 1'b0; #1;
    chk("t3_id2", rdata, 32'h8000_0002);
    wr(4'h0, 32'h3f);
    $display("txn t3 claim");

    // 4: mask
    wr(4'h8, 32'h0);
    wr(4'h4, 32'h3e);
    irq = 6'b000001; cyc();
    chk("t4_masked", {26'd0, hwint}, 32'h0);
    addr = 4'hC; #1;
    chk("t4_id_none", rdata, 32'h0);
    wr(4'h4, 32'h3f);
    chk("t4_unmasked", {26'd0, hwint}, 32'h1);
    $display("txn t4 mask");

    // 5: set beats W1C
    irq = 6'd0;
    wr(4'h8, 32'h3f);
    irq = 6'b001000;
    wr(4'h0, 32'h8);
    addr = 4'h0; #1;
    chk("t5_pend", rdata, 32'h8);
    chk("t5_hwint", {26'd0, hwint}, 32'h8);
    $display("txn t5 collision");

    // 6: reset mid-activity
    irq = 6'h3f; cyc();
    wr(4'h4, 32'h0f);
    chk("t6_hwint", {26'd0, hwint}, 32'h0f);
    reset = 1'b1; cyc();
    reset = 1'b0;
    chk("t6_hwint_rst", {26'd0, hwint}, 32'h0);
    addr = 4'h0; #1; chk("t6_pend", rdata, 32'h0);
    addr = 4'h4; #1; chk("t6_mask", rdata, 32'h3f);
    addr = 4'h8; #1; chk("t6_mode", rdata, 32'h0);
    $display("txn t6 reset");

    // Random traffic, checked every cycle by the model compare.
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      irq   = irq ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
      addr  = 4'($urandom);
      we    = ($urandom_range(0, 3) == 0);
      re    = ($urandom_range(0, 1) == 0);
      wdata = $urandom;
      cyc();
      $display("txn rnd %0d rst=%0b irq=%02h addr=%h we=%0b re=%0b wd=%02h hwint=%02h rdata=%08h",
               n, reset, irq, addr, we, re, wdata[5:0], hwint, rdata);
    end
    reset = 1'b0; we = 1'b0; re = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
